// File: rtl/alu_seq.sv
// alu_seq: multi-cycle command sequencer in front of an external 8-bit
// combinational ALU. It holds a 4x8 register file and runs load-immediate or
// repeated register-to-register ALU ops. The final value and flags go out on
// a response channel.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. Once the sequencer raises rsp_valid it
// keeps rsp_valid, rsp_data and rsp_flags stable until that edge. cmd_ready
// is combinational from state only and never depends on cmd_valid.
`timescale 1ns/1ps
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_imm,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs,
  input  logic [1:0] cmd_rt,
  input  logic [2:0] cmd_cnt,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [1:0]      rd_q, rd_d;
  logic [2:0]      iter_q, iter_d;
  logic            sticky_q, sticky_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rd_d       = rd_q;
    iter_d     = iter_q;
    sticky_d   = sticky_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_imm) begin
            regs_d[cmd_rd] = cmd_data;
            rsp_data_d     = cmd_data;
            sticky_d       = 1'b0;
            carry_d        = 1'b0;
            ovf_d          = 1'b0;
            zero_d         = (cmd_data == 8'h00);
            state_d        = S_RESP;
          end else begin
            // Operands are captured here, so rd may alias rs or rt safely.
            alu_a_d  = regs_q[cmd_rs];
            alu_b_d  = regs_q[cmd_rt];
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            iter_d   = cmd_cnt;
            sticky_d = 1'b0;
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // The ALU result feeds back as operand A; B and op are held.
        alu_a_d  = alu_y;
        carry_d  = alu_carry;
        ovf_d    = alu_overflow;
        zero_d   = alu_zero;
        sticky_d = sticky_q | alu_overflow;
        if (iter_q == 3'd0) begin
          regs_d[rd_q] = alu_y;
          rsp_data_d   = alu_y;
          state_d      = S_RESP;
        end else begin
          iter_d = iter_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      regs_q     <= '0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_op_q   <= 3'd0;
      rd_q       <= 2'd0;
      iter_q     <= 3'd0;
      sticky_q   <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rd_q       <= rd_d;
      iter_q     <= iter_d;
      sticky_q   <= sticky_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = {sticky_q, carry_q, ovf_q, zero_q};
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: bench for alu_seq. It provides a behavioural 8-bit ALU on the
// DUT's ALU port, runs a directed command table, hand-written multi-cycle
// sequences (shift trace, backpressure, resets) and random commands that are
// checked against a register-file model.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_CMP = 3'd7;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_imm;
  logic [2:0] cmd_op, cmd_cnt;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [7:0] cmd_data;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;

  int n_vec = 0;
  int n_err = 0;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_imm(cmd_imm),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ALU ----------------
  // Returns {carry, overflow, zero, y}. Sub carry means "no borrow" (a >= b).
  function automatic logic [10:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] y;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[7:0];
        c = s[8];
        o = (a[7] == b[7]) && (y[7] != a[7]);
      end
      OP_SUB: begin
        y = a - b;
        c = (a >= b);
        o = (a[7] != b[7]) && (y[7] != a[7]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin y = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR: begin y = {1'b0, a[7:1]}; c = a[0]; end
      default: y = (a == b) ? 8'd1 : ((a > b) ? 8'd2 : 8'd0);
    endcase
    return {c, o, (y == 8'h00), y};
  endfunction

  always_comb {alu_carry, alu_overflow, alu_zero, alu_y} = alu_f(alu_op, alu_a, alu_b);

  // ---------------- scoreboard helpers ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic imm, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic [1:0] rt, input logic [2:0] cnt,
                          input logic [7:0] data, output bit ok);
    int g;
    @(negedge clk);
    cmd_imm = imm; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    cmd_cnt = cnt; cmd_data = data; cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    ok = cmd_ready;
    if (!ok) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until rsp_valid shows (1 = cycle T+1).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic run_cmd(input string name, input logic imm, input logic [2:0] op,
                         input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [2:0] cnt, input logic [7:0] data,
                         input logic [7:0] exp_data, input logic [3:0] exp_flags,
                         input int exp_lat, input int bp);
    bit ok;
    int lat;
    rsp_ready = (bp == 0);
    send_cmd(imm, op, rd, rs, rt, cnt, data, ok);
    if (!ok) begin rsp_ready = 1'b1; return; end
    wait_rsp(lat);
    exp_q.push_back(exp_data);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, 32'(rsp_data), 32'(exp_q.pop_front()));
    check({name, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) @(negedge clk);
      check({name, "_hold"}, {rsp_valid, 15'd0, rsp_flags, 4'd0, rsp_data},
            {1'b1, 15'd0, exp_flags, 4'd0, exp_data});
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       imm;
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic [2:0] cnt;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [3:0] exp_flags;
    int         exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic imm, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [1:0] rt, input logic [2:0] cnt,
                              input logic [7:0] data, input logic [7:0] ed,
                              input logic [3:0] ef, input int el);
    vec_t v;
    v.imm = imm; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.cnt = cnt;
    v.data = data; v.exp_data = ed; v.exp_flags = ef; v.exp_lat = el;
    return v;
  endfunction

  vec_t tbl[$];
  logic [7:0] mregs[4];

  initial begin
    bit ok;
    int lat;
    bit seen;
    logic [10:0] r;
    logic [7:0] a, b, d;
    logic sticky;
    logic imm;
    logic [2:0] op, cnt;
    logic [1:0] rd, rs, rt;

    cmd_valid = 1'b0; cmd_imm = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0; cmd_rs = 2'd0;
    cmd_rt = 2'd0; cmd_cnt = 3'd0; cmd_data = 8'h00; rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", {20'd0, rsp_flags, rsp_data}, 32'd0);
    check("rst_alu", {13'd0, alu_op, alu_b, alu_a}, 32'd0);

    // Table: overflow add, readbacks, logic ops, cmp/shr repeats, repeated subtract.
    tbl.push_back(mk(1, OP_ADD, 1, 0, 0, 0, 8'h7F, 8'h7F, 4'b0000, 1));
    tbl.push_back(mk(1, OP_ADD, 2, 0, 0, 0, 8'h01, 8'h01, 4'b0000, 1));
    tbl.push_back(mk(0, OP_ADD, 3, 1, 2, 0, 8'h00, 8'h80, 4'b1010, 2));
    tbl.push_back(mk(0, OP_OR,  3, 3, 3, 0, 8'h00, 8'h80, 4'b0000, 2));
    tbl.push_back(mk(1, OP_ADD, 1, 0, 0, 0, 8'h81, 8'h81, 4'b0000, 1));
    tbl.push_back(mk(1, OP_ADD, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 1));
    tbl.push_back(mk(0, OP_XOR, 0, 1, 2, 0, 8'h00, 8'h80, 4'b0000, 2));
    tbl.push_back(mk(0, OP_CMP, 0, 1, 2, 1, 8'h00, 8'h02, 4'b0000, 3));
    tbl.push_back(mk(0, OP_SHR, 2, 1, 2, 1, 8'h00, 8'h20, 4'b0000, 3));
    tbl.push_back(mk(1, OP_ADD, 3, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 1));
    tbl.push_back(mk(0, OP_AND, 3, 1, 3, 0, 8'h00, 8'h00, 4'b0001, 2));
    tbl.push_back(mk(1, OP_ADD, 1, 0, 0, 0, 8'h05, 8'h05, 4'b0000, 1));
    tbl.push_back(mk(1, OP_ADD, 2, 0, 0, 0, 8'h03, 8'h03, 4'b0000, 1));
    tbl.push_back(mk(0, OP_SUB, 1, 1, 2, 2, 8'h00, 8'hFC, 4'b0100, 4));
    tbl.push_back(mk(0, OP_OR,  1, 1, 1, 0, 8'h00, 8'hFC, 4'b0000, 2));
    for (int i = 0; i < tbl.size(); i++)
      run_cmd($sformatf("tbl%0d", i), tbl[i].imm, tbl[i].op, tbl[i].rd, tbl[i].rs,
              tbl[i].rt, tbl[i].cnt, tbl[i].data, tbl[i].exp_data, tbl[i].exp_flags,
              tbl[i].exp_lat, 0);

    // Repeated shift: trace operand A and carry through each EXEC cycle.
    run_cmd("shl_ld", 1, OP_ADD, 1, 0, 0, 0, 8'h81, 8'h81, 4'b0000, 1, 0);
    send_cmd(0, OP_SHL, 0, 1, 1, 3'd3, 8'h00, ok);
    if (ok) begin
      @(negedge clk); check("shl_a1", 32'(alu_a), 32'h81);
      @(negedge clk); check("shl_a2", 32'(alu_a), 32'h02);
      check("shl_c1", 32'(rsp_flags[2]), 32'd1);
      @(negedge clk); check("shl_a3", 32'(alu_a), 32'h04);
      check("shl_c2", 32'(rsp_flags[2]), 32'd0);
      @(negedge clk); check("shl_a4", 32'(alu_a), 32'h08);
      check("shl_busy", 32'(rsp_valid), 32'd0);
      @(negedge clk); check("shl_valid_t5", 32'(rsp_valid), 32'd1);
      check("shl_rsp", {20'd0, rsp_flags, rsp_data}, {20'd0, 4'b0000, 8'h10});
      @(posedge clk); #1;
    end
    run_cmd("shl_rb", 0, OP_OR, 0, 0, 0, 0, 8'h00, 8'h10, 4'b0000, 2, 0);

    // Backpressure with a pending command waiting on cmd_valid.
    rsp_ready = 1'b0;
    send_cmd(1, OP_ADD, 1, 0, 0, 0, 8'h5A, ok);
    if (ok) begin
      wait_rsp(lat);
      check("bp_lat", 32'(lat), 32'd1);
      cmd_imm = 1'b1; cmd_rd = 2'd2; cmd_data = 8'h33; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp_hold%0d", i), {18'd0, cmd_ready, rsp_valid, rsp_flags, rsp_data},
              {18'd0, 1'b0, 1'b1, 4'b0000, 8'h5A});
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_after_hs", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_pending_rsp", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h33});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;

    // Reset during the 3rd EXEC cycle of a long shift.
    send_cmd(0, OP_SHL, 3, 1, 1, 3'd7, 8'h00, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_ready", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
      check("mrst_alu", {13'd0, alu_op, alu_b, alu_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      check("mrst_no_rsp", 32'(seen), 32'd0);
      check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    run_cmd("mrst_rd", 0, OP_OR, 3, 3, 3, 0, 8'h00, 8'h00, 4'b0001, 2, 0);
    run_cmd("mrst_r1", 0, OP_OR, 1, 1, 1, 0, 8'h00, 8'h00, 4'b0001, 2, 0);
    run_cmd("rst_add", 0, OP_ADD, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 2, 0);

    // Random commands against the register-file model (all registers 0 here).
    for (int k = 0; k < 4; k++) mregs[k] = 8'h00;
    for (int n = 0; n < 60; n++) begin
      imm = ($urandom_range(0, 2) == 0);
      op  = 3'($urandom_range(0, 7));
      rd  = 2'($urandom_range(0, 3));
      rs  = 2'($urandom_range(0, 3));
      rt  = 2'($urandom_range(0, 3));
      cnt = 3'($urandom_range(0, 7));
      d   = 8'($urandom_range(0, 255));
      if (imm) begin
        mregs[rd] = d;
        run_cmd($sformatf("rnd%0d", n), 1'b1, op, rd, rs, rt, cnt, d, d,
                {3'b000, d == 8'h00}, 1, $urandom_range(0, 3));
      end else begin
        a = mregs[rs];
        b = mregs[rt];
        sticky = 1'b0;
        r = '0;
        for (int i = 0; i <= int'(cnt); i++) begin
          r = alu_f(op, a, b);
          sticky = sticky | r[9];
          a = r[7:0];
        end
        mregs[rd] = a;
        run_cmd($sformatf("rnd%0d", n), 1'b0, op, rd, rs, rt, cnt, 8'h00, a,
                {sticky, r[10:8]}, int'(cnt) + 2, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle command sequencer that drives the team's 8-bit combinational ALU from its operand/opcode side and captures its result and flags. It holds a 4×8 register file. It accepts load-immediate and register-to-register ALU commands over a valid/ready interface. An ALU op can be repeated up to 8 times with the result fed back as operand A (multi-bit shifts, repeated add/sub). It returns the final result and flags over a valid/ready response channel.

## Interface
Parameters: none. Widths are fixed: 8-bit data, 4 registers, 3-bit repeat count.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_imm  in  1  1 = load immediate, 0 = ALU op
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 cmp
- cmd_rd  in  2  destination register
- cmd_rs  in  2  source register → operand A
- cmd_rt  in  2  source register → operand B
- cmd_cnt  in  3  repeat count; the op executes cmd_cnt+1 times
- cmd_data  in  8  immediate value
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_op  out  3  ALU opcode (registered)
- alu_y  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_carry, alu_overflow, alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  final result
- rsp_flags  out  4  {sticky_ovf, carry, overflow, zero}

## Operation
- States: IDLE, EXEC, RESP.
- cmd_ready = 1 only in IDLE. A command is accepted on a clk edge where cmd_valid && cmd_ready.
- **IDLE, accept with cmd_imm=1:**
  - reg[rd] ← cmd_data.
  - rsp_data ← cmd_data.
  - rsp_flags ← {0, 0, 0, cmd_data==0}.
  - Next state RESP.
- **IDLE, accept with cmd_imm=0:**
  - alu_a ← reg[rs], alu_b ← reg[rt], alu_op ← cmd_op.
  - Latch rd; iter ← cmd_cnt; sticky_ovf ← 0.
  - Next state EXEC.
  - Operands are latched at accept, so rd==rs or rd==rt is legal.
- **EXEC, each cycle:**
  - alu_a ← alu_y.
  - carry, overflow, zero ← ALU flags.
  - sticky_ovf ← sticky_ovf | alu_overflow.
  - alu_b and alu_op are held.
  - If iter==0: reg[rd] ← alu_y, rsp_data ← alu_y, next state RESP.
  - Otherwise: iter ← iter−1.
- **RESP:**
  - rsp_valid=1; rsp_data and rsp_flags stay stable until the rsp_valid && rsp_ready edge.
  - On that edge, next state IDLE.
- cmp op (111) repeats like any other op: the result (0, 1 = eq, 2 = gt) is fed back as A.
- cmd_valid is ignored outside IDLE. The command is not queued.
- alu_a, alu_b and alu_op hold their last values in IDLE and RESP.
- All arithmetic is 8-bit; the sequencer adds no width extension. Flags are taken verbatim from the ALU.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, alu_a=0, alu_b=0, alu_op=0, all registers 0, iter=0.
- Immediate load: accept edge T; rsp_valid=1 in cycle T+1.
- ALU op, cnt=k: accept edge T; EXEC occupies cycles T+1 … T+k+1; rsp_valid=1 in cycle T+k+2.
- rsp_ready already high when rsp_valid rises: handshake completes that edge. cmd_ready=1 the next cycle, giving one idle cycle between back-to-back commands.
- rst_n asserted mid-EXEC or mid-RESP: immediate return to reset values. The in-flight command is lost with no response and no register write.
- Register write and rsp_data load occur on the same edge as the final EXEC iteration.

## Test plan
- **Reset:** assert rst_n=0 mid-sim → cmd_ready=1, rsp_valid=0, alu_a/b/op=0. Then add r0+r0 → rsp_data=0x00, zero=1.
- **Overflow:** imm r1=0x7F, imm r2=0x01, add r3=r1+r2 cnt=0 → rsp_data=0x80, rsp_flags=4'b1010. rsp_valid exactly 2 cycles after the accept edge.
- **Repeated shift:** imm r1=0x81, shl r0=r1 cnt=3 → alu_a sequence 0x81, 0x02, 0x04, 0x08; carry=1 on the first iteration only; rsp_data=0x10, carry=0, sticky_ovf=0. Latency 5 cycles; r0 reads 0x10.
- **Repeated subtract:** imm r1=0x05, imm r2=0x03, sub r1=r1−r2 cnt=2 → 0x02, 0xFF, 0xFC; rsp_data=0xFC, rsp_flags=4'b0100 (the ALU's carry for 0xFF−0x03). r1 reads 0xFC.
- **Response backpressure:** hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_valid, rsp_data, rsp_flags stable; cmd_ready=0; the pending command is not accepted until 1 cycle after the handshake.
- **Reset mid-EXEC:** shl cnt=7 with rst_n pulsed low during the 3rd EXEC cycle → no response, rd unchanged (0), cmd_ready=1 after release.
